// File: rtl/feexp_seq_if.sv
// -----------------------------------------------------------------------------
// feexp_seq_if
// Request/acknowledge bus between feexp_seq and an external modular multiplier
// working mod 2^255-19.
//
// Signals
//   mul_req : request from feexp_seq
//   mul_x   : first operand
//   mul_y   : second operand
//   mul_ack : result valid from the multiplier
//   mul_z   : mul_x*mul_y mod 2^255-19, meaningful while mul_ack is high
//
// Handshake: a transfer completes on a rising clock edge where mul_req and
// mul_ack are both high. The requester captures mul_z on that edge and drops
// mul_req on it. mul_x/mul_y do not change while mul_req is high. mul_ack
// seen while mul_req is low carries no meaning and is ignored.
//
// Modports: master = feexp_seq side, slave = multiplier side.
// -----------------------------------------------------------------------------
interface feexp_seq_if #(
   parameter int FE_WIDTH = 255
);
   logic                mul_req;
   logic [FE_WIDTH-1:0] mul_x;
   logic [FE_WIDTH-1:0] mul_y;
   logic                mul_ack;
   logic [FE_WIDTH-1:0] mul_z;

   modport master (output mul_req, mul_x, mul_y, input mul_ack, mul_z);
   modport slave  (input mul_req, mul_x, mul_y, output mul_ack, mul_z);
endinterface

// File: rtl/feexp_seq.sv
// -----------------------------------------------------------------------------
// feexp_seq
// Sequential modular exponentiation out = a^e mod 2^255-19. The module uses
// left-to-right square-and-multiply. Every multiplication goes to an external
// multiplier over feexp_seq_if.
//
// Ports
//   clock     : sole clock, rising edge
//   reset     : asynchronous, active-high
//   start     : begin an exponentiation (only accepted in IDLE)
//   a         : base, already reduced mod 2^255-19
//   e         : unsigned exponent
//   busy      : high in SQR, MUL, FIN
//   done      : one-cycle pulse when out becomes valid
//   out       : result, held from done until the next done
//   state_dbg : current FSM state (IDLE=0, SQR=1, MUL=2, FIN=3)
//   mul       : multiplier bus (master side)
//
// Configuration
//   FEEXP_CONST_TIME_EN : when defined, every exponent bit costs exactly one
//     square and one multiply (2*EXP_WIDTH requests). This holds even for
//     leading zeros. A multiply for a 0 bit is issued and its result is
//     dropped. When undefined, leading zeros are skipped and multiplies are
//     only issued for 1 bits.
// -----------------------------------------------------------------------------
module feexp_seq #(
   parameter int EXP_WIDTH = 255,
   parameter int FE_WIDTH  = 255
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [FE_WIDTH-1:0]  a,
   input  logic [EXP_WIDTH-1:0] e,
   output logic                 busy,
   output logic                 done,
   output logic [FE_WIDTH-1:0]  out,
   output logic [1:0]           state_dbg,
   feexp_seq_if.master          mul
);

   localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
   localparam logic [IW-1:0]       IDX_TOP = IW'(EXP_WIDTH - 1);
   localparam logic [FE_WIDTH-1:0] FE_ONE  = FE_WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQR  = 2'd1,
      MUL  = 2'd2,
      FIN  = 2'd3
   } state_t;

   state_t               state_q, state_n;
   logic [FE_WIDTH-1:0]  base_q, base_n;
   logic [EXP_WIDTH-1:0] ex_q, ex_n;
   logic [FE_WIDTH-1:0]  acc_q, acc_n;
   logic [IW-1:0]        idx_q, idx_n;
   logic                 mul_req_q, mul_req_n;
   logic [FE_WIDTH-1:0]  mul_x_q, mul_x_n;
   logic [FE_WIDTH-1:0]  mul_y_q, mul_y_n;
   logic [FE_WIDTH-1:0]  out_q, out_n;
   logic                 done_q, done_n;
   logic                 sqr_issue;
   logic                 advance;
   logic                 cur_bit;

`ifndef FEEXP_CONST_TIME_EN
   // acc_one_q marks that the accumulator still holds the initial 1. While it
   // is set, squaring is pointless. The first set bit of e is then found
   // directly.
   logic                 acc_one_q, acc_one_n;
   logic [IW-1:0]        msb_idx;

   always_comb begin
      msb_idx = '0;
      for (int i = 0; i < EXP_WIDTH; i++) begin
         if (ex_q[i]) msb_idx = IW'(i);
      end
   end
`endif

   assign cur_bit = ex_q[idx_q];

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_n   = state_q;
      base_n    = base_q;
      ex_n      = ex_q;
      acc_n     = acc_q;
      idx_n     = idx_q;
      mul_req_n = mul_req_q;
      mul_x_n   = mul_x_q;
      mul_y_n   = mul_y_q;
      out_n     = out_q;
      done_n    = 1'b0;
      sqr_issue = 1'b0;
      advance   = 1'b0;
`ifndef FEEXP_CONST_TIME_EN
      acc_one_n = acc_one_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               base_n  = a;
               ex_n    = e;
               acc_n   = FE_ONE;
               idx_n   = IDX_TOP;
               state_n = SQR;
`ifndef FEEXP_CONST_TIME_EN
               acc_one_n = 1'b1;
`endif
            end
         end

         SQR: begin
`ifdef FEEXP_CONST_TIME_EN
            sqr_issue = 1'b1;
`else
            sqr_issue = !acc_one_q;
            // Leading zeros: jump straight to the multiply for the top set
            // bit, or finish at once when e is zero.
            if (acc_one_q) begin
               if (ex_q == '0) begin
                  state_n = FIN;
               end else begin
                  idx_n   = msb_idx;
                  state_n = MUL;
               end
            end
`endif
            if (sqr_issue) begin
               if (!mul_req_q) begin
                  mul_req_n = 1'b1;
                  mul_x_n   = acc_q;
                  mul_y_n   = acc_q;
               end else if (mul.mul_ack) begin
                  mul_req_n = 1'b0;
                  acc_n     = mul.mul_z;
`ifdef FEEXP_CONST_TIME_EN
                  state_n   = MUL;
`else
                  if (cur_bit) state_n = MUL;
                  else         advance = 1'b1;
`endif
               end
            end
         end

         MUL: begin
            if (!mul_req_q) begin
               mul_req_n = 1'b1;
               mul_x_n   = acc_q;
               mul_y_n   = base_q;
            end else if (mul.mul_ack) begin
               mul_req_n = 1'b0;
               advance   = 1'b1;
`ifdef FEEXP_CONST_TIME_EN
               // A 0 bit still pays for the multiply; only a 1 bit keeps it.
               if (cur_bit) acc_n = mul.mul_z;
`else
               acc_n     = mul.mul_z;
               acc_one_n = 1'b0;
`endif
            end
         end

         FIN: begin
            out_n   = acc_q;
            done_n  = 1'b1;
            state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase

      if (advance) begin
         if (idx_q == '0) begin
            state_n = FIN;
         end else begin
            idx_n   = idx_q - IW'(1);
            state_n = SQR;
         end
      end
   end

   // ---------------------------------------------------------------- registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         base_q    <= '0;
         ex_q      <= '0;
         acc_q     <= FE_ONE;
         idx_q     <= '0;
         mul_req_q <= 1'b0;
         mul_x_q   <= '0;
         mul_y_q   <= '0;
         out_q     <= '0;
         done_q    <= 1'b0;
`ifndef FEEXP_CONST_TIME_EN
         acc_one_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_n;
         base_q    <= base_n;
         ex_q      <= ex_n;
         acc_q     <= acc_n;
         idx_q     <= idx_n;
         mul_req_q <= mul_req_n;
         mul_x_q   <= mul_x_n;
         mul_y_q   <= mul_y_n;
         out_q     <= out_n;
         done_q    <= done_n;
`ifndef FEEXP_CONST_TIME_EN
         acc_one_q <= acc_one_n;
`endif
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign out         = out_q;
   assign state_dbg   = state_q;
   assign mul.mul_req = mul_req_q;
   assign mul.mul_x   = mul_x_q;
   assign mul.mul_y   = mul_y_q;

endmodule

// File: tb/tb_feexp_seq.sv
// -----------------------------------------------------------------------------
// tb_feexp_seq
// Bench for feexp_seq. It contains the following parts:
//   - a randomized multiplier model with 0-5 cycle ack latency and spurious
//     acks while idle
//   - a driver that pushes expected results into a queue
//   - a monitor that pops and compares whenever done pulses
// The reference is plain right-to-left exponentiation with wide integer mod.
// The expected request count comes from bit length and popcount.
// -----------------------------------------------------------------------------
module tb_feexp_seq;
   localparam int EW        = 255;
   localparam int FW        = 255;
   localparam int OP_BUDGET = 8000;
   localparam logic [511:0] P_MOD = (512'd1 << 255) - 512'd19;

   logic          clock;
   logic          reset;
   logic          start;
   logic [FW-1:0] a;
   logic [EW-1:0] e;
   logic          busy;
   logic          done;
   logic [FW-1:0] out;
   logic [1:0]    state_dbg;

   feexp_seq_if #(.FE_WIDTH(FW)) mif ();

   feexp_seq #(.EXP_WIDTH(EW), .FE_WIDTH(FW)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .e         (e),
      .busy      (busy),
      .done      (done),
      .out       (out),
      .state_dbg (state_dbg),
      .mul       (mif)
   );

   // scoreboard state
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            req_total = 0;
   logic [FW-1:0] exp_q[$];
   int            exp_reqs_q[$];
   int            exp_lat_q[$];
   int            start_cyc_q[$];
   int            req_base_q[$];

   // ---------------------------------------------------------------- clock/reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // ---------------------------------------------------------------- reference
   function automatic logic [511:0] fe_mul(input logic [511:0] x, input logic [511:0] y);
      logic [511:0] t;
      t = x * y;
      return t % P_MOD;
   endfunction

   function automatic logic [511:0] fe_pow(input logic [511:0] base, input logic [511:0] ev);
      logic [511:0] r;
      logic [511:0] b;
      r = 512'd1;
      b = base % P_MOD;
      for (int i = 0; i < EW; i++) begin
         if (ev[i]) r = fe_mul(r, b);
         b = fe_mul(b, b);
      end
      return r;
   endfunction

   function automatic int model_reqs(input logic [EW-1:0] ev);
`ifdef FEEXP_CONST_TIME_EN
      return 2 * EW;
`else
      int bl;
      int pc;
      bl = 0;
      pc = 0;
      for (int i = 0; i < EW; i++) begin
         if (ev[i]) begin
            bl = i + 1;
            pc++;
         end
      end
      return (bl == 0) ? 0 : (bl - 1 + pc);
`endif
   endfunction

   function automatic logic [511:0] rand_wide();
      logic [511:0] t;
      t = {256'd0, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      return t;
   endfunction

   function automatic logic [511:0] rand_fe();
      logic [511:0] t;
      t = rand_wide() & ((512'd1 << 255) - 512'd1);
      return t % P_MOD;
   endfunction

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
      end
   endtask

   // ---------------------------------------------------------------- multiplier model
   initial begin : mul_model
      bit            in_req;
      int            wait_cnt;
      logic [FW-1:0] hx;
      logic [FW-1:0] hy;
      in_req      = 1'b0;
      wait_cnt    = 0;
      hx          = '0;
      hy          = '0;
      mif.mul_ack = 1'b0;
      mif.mul_z   = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            in_req      = 1'b0;
            mif.mul_ack = 1'b0;
         end else if (mif.mul_req) begin
            if (!in_req) begin
               in_req   = 1'b1;
               hx       = mif.mul_x;
               hy       = mif.mul_y;
               wait_cnt = $urandom_range(0, 5);
               req_total++;
            end else begin
               check("mul_x_stable", 512'(mif.mul_x), 512'(hx));
               check("mul_y_stable", 512'(mif.mul_y), 512'(hy));
            end
            if (wait_cnt == 0) begin
               mif.mul_ack = 1'b1;
               mif.mul_z   = FW'(fe_mul(512'(hx), 512'(hy)));
            end else begin
               wait_cnt--;
               mif.mul_ack = 1'b0;
               mif.mul_z   = FW'(rand_wide());
            end
         end else begin
            // Idle: occasional stray ack with junk data.
            in_req      = 1'b0;
            mif.mul_ack = ($urandom_range(0, 7) == 0);
            mif.mul_z   = FW'(rand_wide());
         end
      end
   end

   // ---------------------------------------------------------------- monitor
   initial begin : monitor
      logic [FW-1:0] last_out;
      logic [FW-1:0] want;
      int            wreq;
      int            wlat;
      int            scyc;
      int            rbase;
      last_out = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            last_out = '0;
         end else if (done) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 want done=0 with nothing outstanding");
            end else begin
               want  = exp_q.pop_front();
               wreq  = exp_reqs_q.pop_front();
               wlat  = exp_lat_q.pop_front();
               scyc  = start_cyc_q.pop_front();
               rbase = req_base_q.pop_front();
               check("result", 512'(out), 512'(want));
               check("mul_count", 512'(req_total - rbase), 512'(wreq));
               if (wlat >= 0) check("done_latency", 512'(cyc - scyc + 1), 512'(wlat));
            end
            last_out = out;
         end else begin
            check("out_hold", 512'(out), 512'(last_out));
         end
      end
   end

   // ---------------------------------------------------------------- driver
   // Called at a negedge. Waits for idle, then issues one operation.
   task automatic run_op(input logic [511:0] av, input logic [511:0] ev,
                         input logic [511:0] want, input bit poke);
      int            guard;
      logic [EW-1:0] et;
      guard = 0;
      while (busy && guard < OP_BUDGET) begin
         @(negedge clock);
         guard++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got busy=1 after %0d cycles want busy=0", guard);
         return;
      end
      et = EW'(ev);
      exp_q.push_back(FW'(want));
      exp_reqs_q.push_back(model_reqs(et));
`ifdef FEEXP_CONST_TIME_EN
      exp_lat_q.push_back(-1);
`else
      exp_lat_q.push_back((et == '0) ? 3 : -1);
`endif
      start_cyc_q.push_back(cyc + 1);
      req_base_q.push_back(req_total);
      a     = FW'(av);
      e     = et;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("busy_after_start", 512'(busy), 512'd1);
      // Scramble inputs; the captured copies must be used.
      a = FW'(rand_wide());
      e = EW'(rand_wide());
      if (poke) begin
         @(negedge clock);
         if (busy) begin
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < OP_BUDGET) begin
         @(negedge clock);
         guard++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d results outstanding want 0", exp_q.size());
         exp_q.delete();
         exp_reqs_q.delete();
         exp_lat_q.delete();
         start_cyc_q.delete();
         req_base_q.delete();
      end
   endtask

   // ---------------------------------------------------------------- main
   initial begin : main
      logic [511:0] av;
      logic [511:0] ev;
      int           len;
      int           guard;
      reset = 1'b1;
      start = 1'b0;
      a     = '0;
      e     = '0;
      repeat (3) @(negedge clock);
      check("rst_busy",    512'(busy),        512'd0);
      check("rst_done",    512'(done),        512'd0);
      check("rst_mul_req", 512'(mif.mul_req), 512'd0);
      check("rst_out",     512'(out),         512'd0);
      check("rst_mul_x",   512'(mif.mul_x),   512'd0);
      check("rst_mul_y",   512'(mif.mul_y),   512'd0);
      check("rst_state",   512'(state_dbg),   512'd0);
      reset = 1'b0;

      // Start on the first edge after reset release.
      run_op(512'd7, 512'd2, 512'd49, 1'b0);
      run_op(512'd2, 512'd255, 512'd19, 1'b1);
      run_op(512'd2, 512'd254, 512'd1 << 254, 1'b0);
      run_op(512'd1 << 128, 512'd2, 512'd38, 1'b1);
      run_op(512'd7, P_MOD - 512'd2, (512'd2 * P_MOD + 512'd1) / 512'd7, 1'b0);
      run_op(rand_fe(), 512'd0, 512'd1, 1'b1);
      run_op(512'd0, 512'd0, 512'd1, 1'b0);
      run_op(512'd0, 512'd5, 512'd0, 1'b0);
      av = rand_fe();
      run_op(av, 512'd1, av, 1'b0);
      av = rand_fe();
      ev = (512'd1 << EW) - 512'd1;
      run_op(av, ev, fe_pow(av, ev), 1'b1);
      drain();

      // Abort in the middle of a square.
      a     = FW'(rand_fe());
      e     = '1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      guard = 0;
      while (!(state_dbg == 2'd1 && mif.mul_req) && guard < OP_BUDGET) begin
         @(negedge clock);
         guard++;
      end
      check("reach_sqr_req", 512'(state_dbg == 2'd1 && mif.mul_req), 512'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_busy",    512'(busy),        512'd0);
      check("abort_mul_req", 512'(mif.mul_req), 512'd0);
      check("abort_state",   512'(state_dbg),   512'd0);
      check("abort_done",    512'(done),        512'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      run_op(512'd7, 512'd2, 512'd49, 1'b0);

      // Random operations with varied exponent lengths.
      for (int n = 0; n < 10; n++) begin
         av  = rand_fe();
         len = $urandom_range(1, EW);
         ev  = rand_wide() & ((512'd1 << len) - 512'd1);
         run_op(av, ev, fe_pow(av, ev), 1'($urandom_range(0, 1)));
      end
      drain();

      repeat (5) @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
